// File: rtl/lsu_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_if
// Purpose  : Word-addressed data-memory req/ack bus between LSU and memory.
// Revision : 1.0
// ============================================================================
interface lsu_mem_if #(
    parameter int ADDR_W = 10
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Purpose  : MIPS lw/sw decode, range-checked EA, single-outstanding mem access.
// Revision : 1.0
// ============================================================================
module lsu_mem_initiator #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [31:0] Instruction,
    input  wire logic        instr_valid,
    input  wire logic [31:0] base_value,
    input  wire logic [31:0] store_value,
    output logic             instr_ready,
    lsu_mem_if.master        mem_bus,
    output logic             wb_valid,
    output logic [4:0]       wb_reg,
    output logic [31:0]      wb_data,
    output logic             store_done,
    output logic             err,
    output logic [1:0]       err_code
);
    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_REQ       = 2'd1;
    localparam logic [1:0] c_RESP      = 2'd2;
    localparam logic [5:0] c_OP_LW     = 6'b100011;
    localparam logic [5:0] c_OP_SW     = 6'b101011;
    localparam logic [1:0] c_ERR_RANGE = 2'b01;
    localparam logic [1:0] c_ERR_TOUT  = 2'b10;
    localparam logic [1:0] c_ERR_OPC   = 2'b11;
    localparam logic [7:0] c_TO_LAST   = 8'(TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [4:0]        r_rt;
    logic [4:0]        r_wb_reg;
    logic [31:0]       r_wb_data;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [1:0]        r_err_code;

    logic [5:0]        w_op;
    logic [4:0]        w_rt;
    logic [15:0]       w_off;
    logic [31:0]       w_ea;
    logic              w_is_mem;
    logic              w_in_range;
    logic              w_accept;
    logic              w_go;
    logic              w_ack;
    logic              w_timeout;
    logic              w_unused_rs;

    assign w_op        = Instruction[31:26];
    assign w_rt        = Instruction[20:16];
    assign w_off       = Instruction[15:0];
    assign w_unused_rs = ^Instruction[25:21];
    // Wrap is defined by the 32-bit sum, so a negative offset can reach word 0.
    assign w_ea        = base_value + {{16{w_off[15]}}, w_off};
    assign w_is_mem    = (w_op == c_OP_LW) || (w_op == c_OP_SW);
    assign w_in_range  = (w_ea[31:ADDR_W] == '0);
    assign w_accept    = (r_state == c_IDLE) && instr_valid;
    assign w_go        = w_accept && w_is_mem && w_in_range;
    assign w_ack       = (r_state == c_REQ) && mem_bus.mem_ack;
    // An ack on the boundary cycle wins over the timeout.
    assign w_timeout   = (r_state == c_REQ) && !mem_bus.mem_ack && (r_cnt == c_TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_go) w_state_next = c_REQ;
            c_REQ: begin
                if (w_ack)          w_state_next = c_RESP;
                else if (w_timeout) w_state_next = c_IDLE;
            end
            c_RESP:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        instr_ready       = (r_state == c_IDLE);
        mem_bus.mem_req   = (r_state == c_REQ);
        mem_bus.mem_we    = r_we;
        mem_bus.mem_addr  = r_addr;
        mem_bus.mem_wdata = r_wdata;
        wb_valid          = (r_state == c_RESP) && !r_we && (r_rt != 5'd0);
        store_done        = (r_state == c_RESP) && r_we;
        wb_reg            = r_wb_reg;
        wb_data           = r_wb_data;
        err               = r_err;
        err_code          = r_err_code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= 8'd0;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= 32'd0;
            r_rt       <= 5'd0;
            r_rdata    <= 32'd0;
            r_wb_reg   <= 5'd0;
            r_wb_data  <= 32'd0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            if (w_go) begin
                r_addr  <= w_ea[ADDR_W-1:0];
                r_we    <= (w_op == c_OP_SW);
                r_wdata <= store_value;
                r_rt    <= w_rt;
                r_cnt   <= 8'd0;
            end else if ((r_state == c_REQ) && !mem_bus.mem_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ack && !r_we) begin
                r_rdata <= mem_bus.mem_rdata;
            end
            // Writeback fields only move when a pulse will be shown, so they hold otherwise.
            if (w_ack && !r_we && (r_rt != 5'd0)) begin
                r_wb_reg  <= r_rt;
                r_wb_data <= mem_bus.mem_rdata;
            end
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            if (w_accept && !w_is_mem) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_OPC;
            end else if (w_accept && !w_in_range) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_RANGE;
            end else if (w_timeout) begin
                r_err      <= 1'b1;
                r_err_code <= c_ERR_TOUT;
            end
        end
    end
endmodule
`default_nettype wire
